// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory stage of a simple in-order pipeline. Holds a small word-addressed
// data memory and the MEM/WB pipeline register.
//
// A load or store takes two cycles:
//   - IDLE sees the request, drops ReadyOut so upstream freezes its inputs,
//     and pushes a bubble into MEM/WB.
//   - ACCESS reads or writes the memory and loads MEM/WB on the exit edge.
// A non-memory instruction passes through MEM/WB in one cycle.
//
// Parameters
//   N      data-path width
//   DEPTH  number of data-memory words
//   BASE   byte address that maps to word 0
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ALU_ResIn         effective byte address, or the result of a non-memory op
//   Val_RmIn          store data
//   MEM_R_ENIn        load request
//   MEM_W_ENIn        store request
//   WB_ENIn           write-back enable
//   WB_DestIn         write-back destination register
//   ALU_ResOut        registered ALU result
//   DataMemoryOut     registered load data
//   MEM_R_ENOut       registered load flag
//   WB_ENOut          registered write-back enable
//   WB_DestOut        registered write-back destination
//   ReadyOut          combinational; 0 means upstream must hold its inputs
//   AddrErrOut        sticky out-of-range flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int BASE  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ALU_ResIn,
    input  logic [N-1:0] Val_RmIn,
    input  logic         MEM_R_ENIn,
    input  logic         MEM_W_ENIn,
    input  logic         WB_ENIn,
    input  logic [3:0]   WB_DestIn,
    output logic [N-1:0] ALU_ResOut,
    output logic [N-1:0] DataMemoryOut,
    output logic         MEM_R_ENOut,
    output logic         WB_ENOut,
    output logic [3:0]   WB_DestOut,
    output logic         ReadyOut,
    output logic         AddrErrOut
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   mem [DEPTH];

    logic           mem_req;
    logic           in_range;
    logic [AW-1:0]  idx;
    logic [N-1:0]   rd_data;

    // The comparison runs two bits wider than the data path so that
    // BASE + 4*DEPTH can never wrap and make a high address look in range.
    function automatic logic addr_in_range(input logic [N-1:0] addr);
        logic [N+1:0] lo;
        logic [N+1:0] hi;
        logic [N+1:0] a;
        lo = (N+2)'(BASE);
        hi = (N+2)'(BASE + 4 * DEPTH);
        a  = {2'b00, addr};
        return (a >= lo) && (a < hi);
    endfunction

    // Word index: drop the byte-offset bits of (address - BASE).
    function automatic logic [AW-1:0] word_index(input logic [N-1:0] addr);
        return AW'((addr - N'(BASE)) >> 2);
    endfunction

    assign mem_req  = MEM_R_ENIn || MEM_W_ENIn;
    assign in_range = addr_in_range(ALU_ResIn);
    assign idx      = word_index(ALU_ResIn);

    // Out-of-range loads read as zero. The read happens before any write on
    // the same edge, so a combined load+store returns the pre-write word.
    assign rd_data  = in_range ? mem[idx] : '0;

    // Stall only on the first cycle of a memory access; reset forces ready.
    assign ReadyOut = rst || (state == ACCESS) || !mem_req;

    // ---- MEM -> WB boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over everything, including a store pending in ACCESS.
            state         <= IDLE;
            ALU_ResOut    <= '0;
            DataMemoryOut <= '0;
            MEM_R_ENOut   <= 1'b0;
            WB_ENOut      <= 1'b0;
            WB_DestOut    <= '0;
            AddrErrOut    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        // Stall edge: bubble into WB, data fields hold.
                        state       <= ACCESS;
                        MEM_R_ENOut <= 1'b0;
                        WB_ENOut    <= 1'b0;
                    end else begin
                        // Non-memory op; DataMemoryOut holds.
                        ALU_ResOut  <= ALU_ResIn;
                        MEM_R_ENOut <= MEM_R_ENIn;
                        WB_ENOut    <= WB_ENIn;
                        WB_DestOut  <= WB_DestIn;
                    end
                end

                ACCESS: begin
                    // Exit edge: the only edge on which memory is touched,
                    // so each store is written exactly once.
                    state       <= IDLE;
                    ALU_ResOut  <= ALU_ResIn;
                    MEM_R_ENOut <= MEM_R_ENIn;
                    WB_ENOut    <= WB_ENIn;
                    WB_DestOut  <= WB_DestIn;

                    if (MEM_R_ENIn) begin
                        DataMemoryOut <= rd_data;
                    end

                    if (MEM_W_ENIn && in_range) begin
                        mem[idx] <= Val_RmIn;
                    end

                    if (mem_req && !in_range) begin
                        AddrErrOut <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALU_ResIn;
    logic [31:0] Val_RmIn;
    logic        MEM_R_ENIn;
    logic        MEM_W_ENIn;
    logic        WB_ENIn;
    logic [3:0]  WB_DestIn;
    logic [31:0] ALU_ResOut;
    logic [31:0] DataMemoryOut;
    logic        MEM_R_ENOut;
    logic        WB_ENOut;
    logic [3:0]  WB_DestOut;
    logic        ReadyOut;
    logic        AddrErrOut;

    int nvec = 0;
    int nerr = 0;

    mem_stage #(.N(32), .DEPTH(64), .BASE(1024)) dut (
        .clk           (clk),
        .rst           (rst),
        .ALU_ResIn     (ALU_ResIn),
        .Val_RmIn      (Val_RmIn),
        .MEM_R_ENIn    (MEM_R_ENIn),
        .MEM_W_ENIn    (MEM_W_ENIn),
        .WB_ENIn       (WB_ENIn),
        .WB_DestIn     (WB_DestIn),
        .ALU_ResOut    (ALU_ResOut),
        .DataMemoryOut (DataMemoryOut),
        .MEM_R_ENOut   (MEM_R_ENOut),
        .WB_ENOut      (WB_ENOut),
        .WB_DestOut    (WB_DestOut),
        .ReadyOut      (ReadyOut),
        .AddrErrOut    (AddrErrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ALU_ResIn  = '0;
        Val_RmIn   = '0;
        MEM_R_ENIn = 1'b0;
        MEM_W_ENIn = 1'b0;
        WB_ENIn    = 1'b0;
        WB_DestIn  = '0;
    endtask

    // One full two-cycle memory access, checking the stall and the bubble.
    task automatic mem_op(input string tag, input logic r, input logic w,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic wb, input logic [3:0] dest);
        ALU_ResIn  = addr;
        Val_RmIn   = data;
        MEM_R_ENIn = r;
        MEM_W_ENIn = w;
        WB_ENIn    = wb;
        WB_DestIn  = dest;
        #1;
        check({tag, ".ready_stall"}, 32'(ReadyOut), 32'd0);
        tick();
        check({tag, ".bubble_wb"}, 32'(WB_ENOut), 32'd0);
        check({tag, ".bubble_mr"}, 32'(MEM_R_ENOut), 32'd0);
        check({tag, ".ready_access"}, 32'(ReadyOut), 32'd1);
        tick();
        clear_inputs();
    endtask

    initial begin
        // Reset with a load request present: ready must stay high.
        clear_inputs();
        rst        = 1'b1;
        MEM_R_ENIn = 1'b1;
        #1;
        check("rst.ready", 32'(ReadyOut), 32'd1);
        tick();
        tick();
        check("rst.alu",   ALU_ResOut, 32'd0);
        check("rst.dmo",   DataMemoryOut, 32'd0);
        check("rst.mr",    32'(MEM_R_ENOut), 32'd0);
        check("rst.wb",    32'(WB_ENOut), 32'd0);
        check("rst.dest",  32'(WB_DestOut), 32'd0);
        check("rst.err",   32'(AddrErrOut), 32'd0);
        rst = 1'b0;
        clear_inputs();

        // Non-memory instruction: one cycle, no stall.
        ALU_ResIn = 32'd5;
        WB_ENIn   = 1'b1;
        WB_DestIn = 4'd3;
        #1;
        check("alu.ready", 32'(ReadyOut), 32'd1);
        tick();
        clear_inputs();
        check("alu.res",  ALU_ResOut, 32'd5);
        check("alu.wb",   32'(WB_ENOut), 32'd1);
        check("alu.dest", 32'(WB_DestOut), 32'd3);
        check("alu.mr",   32'(MEM_R_ENOut), 32'd0);

        // Store 0xDEADBEEF at 1028; bubble must hold ALU/dest from before.
        ALU_ResIn  = 32'd1028;
        Val_RmIn   = 32'hDEADBEEF;
        MEM_W_ENIn = 1'b1;
        #1;
        check("st1.ready_stall", 32'(ReadyOut), 32'd0);
        tick();
        check("st1.bubble_wb",   32'(WB_ENOut), 32'd0);
        check("st1.bubble_mr",   32'(MEM_R_ENOut), 32'd0);
        check("st1.hold_alu",    ALU_ResOut, 32'd5);
        check("st1.hold_dest",   32'(WB_DestOut), 32'd3);
        check("st1.ready_access", 32'(ReadyOut), 32'd1);
        tick();
        clear_inputs();
        check("st1.alu", ALU_ResOut, 32'd1028);
        check("st1.dmo_hold", DataMemoryOut, 32'd0);

        // Load it back.
        mem_op("ld1", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 4'd7);
        check("ld1.dmo",  DataMemoryOut, 32'hDEADBEEF);
        check("ld1.mr",   32'(MEM_R_ENOut), 32'd1);
        check("ld1.wb",   32'(WB_ENOut), 32'd1);
        check("ld1.dest", 32'(WB_DestOut), 32'd7);
        check("ld1.err",  32'(AddrErrOut), 32'd0);

        // Simultaneous load and store returns the old word.
        mem_op("st7", 1'b0, 1'b1, 32'd1028, 32'd7, 1'b0, 4'd0);
        mem_op("ldst", 1'b1, 1'b1, 32'd1028, 32'd9, 1'b1, 4'd2);
        check("ldst.dmo", DataMemoryOut, 32'd7);
        mem_op("ld9", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 4'd2);
        check("ld9.dmo", DataMemoryOut, 32'd9);

        // Out of range: 1020 would alias word 63 if not guarded.
        mem_op("st0", 1'b0, 1'b1, 32'd1024, 32'h11, 1'b0, 4'd0);
        check("st0.err", 32'(AddrErrOut), 32'd0);
        mem_op("stlo", 1'b0, 1'b1, 32'd1020, 32'hAA, 1'b0, 4'd0);
        check("stlo.err", 32'(AddrErrOut), 32'd1);
        mem_op("ld1027", 1'b1, 1'b0, 32'd1027, 32'd0, 1'b1, 4'd1);
        check("ld1027.dmo", DataMemoryOut, 32'h11);
        mem_op("ld1276", 1'b1, 1'b0, 32'd1276, 32'd0, 1'b1, 4'd1);
        check("ld1276.dmo", DataMemoryOut, 32'd0);
        mem_op("ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 4'd1);
        check("ld1024.dmo", DataMemoryOut, 32'h11);
        mem_op("ld1280", 1'b1, 1'b0, 32'd1280, 32'd0, 1'b1, 4'd1);
        check("ld1280.dmo", DataMemoryOut, 32'd0);
        check("ld1280.err", 32'(AddrErrOut), 32'd1);

        // Leave nonzero state in the outputs before the mid-access reset.
        mem_op("ldpre", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 4'd5);
        check("ldpre.dmo", DataMemoryOut, 32'h11);

        // Reset while in ACCESS with a store pending.
        ALU_ResIn  = 32'd1032;
        Val_RmIn   = 32'h55;
        MEM_W_ENIn = 1'b1;
        WB_ENIn    = 1'b1;
        WB_DestIn  = 4'd4;
        #1;
        tick();
        rst = 1'b1;
        #1;
        check("rmid.ready", 32'(ReadyOut), 32'd1);
        tick();
        check("rmid.alu",  ALU_ResOut, 32'd0);
        check("rmid.dmo",  DataMemoryOut, 32'd0);
        check("rmid.mr",   32'(MEM_R_ENOut), 32'd0);
        check("rmid.wb",   32'(WB_ENOut), 32'd0);
        check("rmid.dest", 32'(WB_DestOut), 32'd0);
        check("rmid.err",  32'(AddrErrOut), 32'd0);
        rst = 1'b0;
        clear_inputs();
        #1;
        check("rmid.ready_idle", 32'(ReadyOut), 32'd1);

        mem_op("ld1032", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b1, 4'd6);
        check("ld1032.dmo", DataMemoryOut, 32'd0);
        mem_op("st66", 1'b0, 1'b1, 32'd1036, 32'h66, 1'b0, 4'd0);
        mem_op("ld1036", 1'b1, 1'b0, 32'd1036, 32'd0, 1'b1, 4'd6);
        check("ld1036.dmo", DataMemoryOut, 32'h66);
        mem_op("ldclr", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 4'd6);
        check("ldclr.dmo", DataMemoryOut, 32'd0);
        check("ldclr.err", 32'(AddrErrOut), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
